// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift_reg_enr word shift register.
// Holds the mode encoding and the fill-counter width helper.
// Optional feature macro used by importers: SHIFT_REG_ROTATE_EN.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    LOAD = 2'b01,
    SHL  = 2'b10,
    SHR  = 2'b11
  } mode_t;

  // Counter width wide enough to represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/word_flopenr.sv
// Purpose: WIDTH-bit register with synchronous active-high reset and enable.
// Latency: one clk edge from d/en to q. Backpressure: none, en simply holds.
// Ports: clk, reset (sync, high), en (load d), d (next word), q (stored word).
module word_flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset takes priority over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_reg_enr.sv
// Purpose: DEPTH x WIDTH staging/serialiser register with load, shift-left,
//          shift-right, sync reset, enable and a saturating fill counter.
// Latency: one clk edge from an enabled command to updated q; sout is combinational.
// Backpressure: none; E=0 or mode=HOLD freezes all state.
// Ports: clk, reset (sync, high), E (enable), mode (HOLD/LOAD/SHL/SHR),
//        d_par (parallel load), sin (serial in), q (contents), sout (word leaving
//        on the next shift), fill_cnt (valid words, saturating), full.
// Build option: define SHIFT_REG_ROTATE_EN to make shifts rotate (sin ignored,
//               fill_cnt unchanged by shifts).
module shift_reg_enr
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       E,
  input  logic [1:0]                 mode,
  input  logic [WIDTH*DEPTH-1:0]     d_par,
  input  logic [WIDTH-1:0]           sin,
  output logic [WIDTH*DEPTH-1:0]     q,
  output logic [WIDTH-1:0]           sout,
  output logic [cnt_w(DEPTH)-1:0]    fill_cnt,
  output logic                       full
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  mode_t mode_e;
  assign mode_e = mode_t'(mode);

  logic [WIDTH-1:0] word [DEPTH];
  logic [WIDTH-1:0] nxt  [DEPTH];

  // HOLD never needs to write, so keep the flops quiet in that case too.
  logic word_en;
  assign word_en = E && (mode_e != HOLD);

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [WIDTH-1:0] shl_src;
    logic [WIDTH-1:0] shr_src;

    // SHL moves words towards higher indices; word 0 takes the new entry.
    if (i == 0) begin : g_shl_end
`ifdef SHIFT_REG_ROTATE_EN
      assign shl_src = word[DEPTH-1];
`else
      assign shl_src = sin;
`endif
    end else begin : g_shl_mid
      assign shl_src = word[i-1];
    end

    // SHR moves words towards lower indices; word DEPTH-1 takes the new entry.
    if (i == DEPTH-1) begin : g_shr_end
`ifdef SHIFT_REG_ROTATE_EN
      assign shr_src = word[0];
`else
      assign shr_src = sin;
`endif
    end else begin : g_shr_mid
      assign shr_src = word[i+1];
    end

    always_comb begin
      nxt[i] = word[i];
      case (mode_e)
        LOAD:    nxt[i] = d_par[i*WIDTH +: WIDTH];
        SHL:     nxt[i] = shl_src;
        SHR:     nxt[i] = shr_src;
        default: nxt[i] = word[i];
      endcase
    end

    word_flopenr #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .reset (reset),
      .en    (word_en),
      .d     (nxt[i]),
      .q     (word[i])
    );

    assign q[i*WIDTH +: WIDTH] = word[i];
  end

  // The word that falls off the end is the one at the far side of the shift.
  assign sout = (mode_e == SHR) ? word[0] : word[DEPTH-1];

  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = fill_cnt;
    if (E) begin
      case (mode_e)
        LOAD: cnt_nxt = DEPTH_C;
        SHL, SHR: begin
`ifndef SHIFT_REG_ROTATE_EN
          if (fill_cnt != DEPTH_C) begin
            cnt_nxt = fill_cnt + 1'b1;
          end
`endif
        end
        default: cnt_nxt = fill_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt <= '0;
    end else begin
      fill_cnt <= cnt_nxt;
    end
  end

  assign full = (fill_cnt == DEPTH_C);

endmodule

// File: tb/tb_shift_reg_enr.sv
// Directed bench for shift_reg_enr (WIDTH=8, DEPTH=4) with a reference model
// kept as a packed 32-bit value updated by whole-register shift arithmetic.
// Checks mid-low phase (before the edge) and mid-high phase (after the edge).
module tb_shift_reg_enr;

  localparam int W = 8;
  localparam int D = 4;

  logic          clk;
  logic          reset;
  logic          E;
  logic [1:0]    mode;
  logic [31:0]   d_par;
  logic [7:0]    sin;
  logic [31:0]   q;
  logic [7:0]    sout;
  logic [2:0]    fill_cnt;
  logic          full;

  shift_reg_enr #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .E        (E),
    .mode     (mode),
    .d_par    (d_par),
    .sin      (sin),
    .q        (q),
    .sout     (sout),
    .fill_cnt (fill_cnt),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  bit [31:0] mq = 32'h0;
  int        mcnt = 0;
  bit        model_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    bit [31:0] exp_sout;
    if (!model_valid) return;
    exp_sout = (mode == 2'b11) ? (mq & 32'hFF) : (mq >> 24);
    chk({tag, "_q"},    q,                 mq);
    chk({tag, "_fill"}, {29'd0, fill_cnt}, mcnt);
    chk({tag, "_full"}, {31'd0, full},     (mcnt == D) ? 32'd1 : 32'd0);
    chk({tag, "_sout"}, {24'd0, sout},     exp_sout);
  endtask

  // Drive new inputs just after the falling edge, then check mid-low phase.
  task automatic drive(input logic r, input logic e, input logic [1:0] md,
                       input logic [31:0] dp, input logic [7:0] s);
    @(negedge clk);
    reset = r;
    E     = e;
    mode  = md;
    d_par = dp;
    sin   = s;
    #2;
    chk_model("pre");
  endtask

  // Take the rising edge, advance the model, check mid-high phase.
  task automatic edge_update();
    @(posedge clk);
    if (reset) begin
      mq   = 32'h0;
      mcnt = 0;
    end else if (E) begin
      case (mode)
        2'b01: begin
          mq   = d_par;
          mcnt = D;
        end
        2'b10: begin
`ifdef SHIFT_REG_ROTATE_EN
          mq = (mq << 8) | (mq >> 24);
`else
          mq   = (mq << 8) | {24'd0, sin};
          mcnt = (mcnt < D) ? mcnt + 1 : D;
`endif
        end
        2'b11: begin
`ifdef SHIFT_REG_ROTATE_EN
          mq = (mq >> 8) | (mq << 24);
`else
          mq   = (mq >> 8) | ({24'd0, sin} << 24);
          mcnt = (mcnt < D) ? mcnt + 1 : D;
`endif
        end
        default: ;
      endcase
    end
    model_valid = 1'b1;
    #2;
    chk_model("post");
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic [31:0] dp, input logic [7:0] s);
    drive(r, e, md, dp, s);
    edge_update();
  endtask

  initial begin
    reset = 1'b1;
    E     = 1'b0;
    mode  = 2'b00;
    d_par = '0;
    sin   = '0;

    // Reset state
    step(1'b1, 1'b0, 2'b00, 32'h0, 8'h0);
    chk("rst_q", q, 32'h0);
    chk("rst_fill", {29'd0, fill_cnt}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);

    // Test 1: E=0 blocks a LOAD across two edges
    step(1'b0, 1'b0, 2'b01, 32'hDEADBEEF, 8'h0);
    step(1'b0, 1'b0, 2'b01, 32'hDEADBEEF, 8'h0);
    chk("t1_q", q, 32'h0);
    chk("t1_fill", {29'd0, fill_cnt}, 32'd0);
    chk("t1_full", {31'd0, full}, 32'd0);

    // Test 2: LOAD visible only after the edge
    drive(1'b0, 1'b1, 2'b01, 32'h11223344, 8'h0);
    chk("t2_q_pre", q, 32'h0);
    edge_update();
    chk("t2_q", q, 32'h11223344);
    chk("t2_fill", {29'd0, fill_cnt}, 32'd4);
    chk("t2_full", {31'd0, full}, 32'd1);

    // Test 3: SHL from a full register
    drive(1'b0, 1'b1, 2'b10, 32'h0, 8'hAA);
    chk("t3_sout_pre", {24'd0, sout}, 32'h11);
    edge_update();
`ifdef SHIFT_REG_ROTATE_EN
    chk("t3_q", q, 32'h22334411);
`else
    chk("t3_q", q, 32'h223344AA);
`endif
    chk("t3_fill", {29'd0, fill_cnt}, 32'd4);

    // HOLD with E=1 and a shift with E=0 both leave state alone
    step(1'b0, 1'b1, 2'b00, 32'hFFFFFFFF, 8'h55);
    step(1'b0, 1'b0, 2'b11, 32'hFFFFFFFF, 8'h55);
`ifdef SHIFT_REG_ROTATE_EN
    chk("hold_q", q, 32'h22334411);
`else
    chk("hold_q", q, 32'h223344AA);
`endif

`ifndef SHIFT_REG_ROTATE_EN
    // Test 4: fill from empty with SHR, then saturate
    step(1'b1, 1'b0, 2'b00, 32'h0, 8'h0);
    step(1'b0, 1'b1, 2'b11, 32'h0, 8'h01);
    step(1'b0, 1'b1, 2'b11, 32'h0, 8'h02);
    step(1'b0, 1'b1, 2'b11, 32'h0, 8'h03);
    chk("t4_q3", q, 32'h03020100);
    chk("t4_fill3", {29'd0, fill_cnt}, 32'd3);
    chk("t4_full3", {31'd0, full}, 32'd0);
    step(1'b0, 1'b1, 2'b11, 32'h0, 8'h04);
    chk("t4_q4", q, 32'h04030201);
    chk("t4_full4", {31'd0, full}, 32'd1);
    step(1'b0, 1'b1, 2'b11, 32'h0, 8'h05);
    chk("t4_q5", q, 32'h05040302);
    chk("t4_fill5", {29'd0, fill_cnt}, 32'd4);
`endif

    // Test 5: reset wins over an enabled LOAD
    step(1'b0, 1'b1, 2'b01, 32'h11223344, 8'h0);
    step(1'b1, 1'b1, 2'b01, 32'hFFFFFFFF, 8'h0);
    chk("t5_q", q, 32'h0);
    chk("t5_fill", {29'd0, fill_cnt}, 32'd0);

`ifdef SHIFT_REG_ROTATE_EN
    // Test 6: rotate left then right restores the word order
    step(1'b0, 1'b1, 2'b01, 32'h11223344, 8'h0);
    step(1'b0, 1'b1, 2'b10, 32'h0, 8'hAA);
    chk("t6_q_shl", q, 32'h22334411);
    step(1'b0, 1'b1, 2'b11, 32'h0, 8'hAA);
    chk("t6_q_shr", q, 32'h11223344);
    chk("t6_fill", {29'd0, fill_cnt}, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
